// File: rtl/dsp_boot_seq.sv
// Blackfin boot/reset sequencer: waits for DCM lock, holds both DSPs in reset with boot straps
// driven, releases them staggered, and re-runs the sequence on a debounced reset-button press.
module dsp_boot_seq #(
    parameter int unsigned LOCK_SETTLE     = 256,
    parameter int unsigned RST_CYCLES      = 64,
    parameter int unsigned STAGGER_CYCLES  = 16,
    parameter int unsigned BMODE_HOLD      = 32,
    parameter int unsigned DEBOUNCE_CYCLES = 1024,
    parameter logic [1:0]  BMODE_DEFAULT   = 2'b01
) (
    input  logic       DSP_CLKIN,
    input  logic       xRESET,
    input  logic       LOCKED_IN,
    input  logic       BUTTON_IN,
    input  logic [1:0] DSP0_BMODE_IN,
    input  logic [1:0] DSP1_BMODE_IN,
    input  logic       BYPASS_IN,
    output logic       DSP0_RESET_N,
    output logic       DSP1_RESET_N,
    output logic [1:0] DSP0_BMODE,
    output logic [1:0] DSP1_BMODE,
    output logic       DSP_PLL_BYPASS,
    output logic       BOOT_DONE,
    output logic [2:0] STATE_MON
);

    localparam int unsigned MaxAB = (LOCK_SETTLE > RST_CYCLES) ? LOCK_SETTLE : RST_CYCLES;
    localparam int unsigned MaxCD = (STAGGER_CYCLES > BMODE_HOLD) ? STAGGER_CYCLES : BMODE_HOLD;
    localparam int unsigned MaxT  = (MaxAB > MaxCD) ? MaxAB : MaxCD;
    localparam int unsigned CntW  = $clog2(MaxT) + 1;
    localparam int unsigned DebW  = $clog2(DEBOUNCE_CYCLES) + 1;

    localparam logic [CntW-1:0] SettleLast  = CntW'(LOCK_SETTLE - 1);
    localparam logic [CntW-1:0] RstLast     = CntW'(RST_CYCLES - 1);
    localparam logic [CntW-1:0] StaggerLast = (STAGGER_CYCLES == 0) ? '0 : CntW'(STAGGER_CYCLES - 1);
    localparam logic [CntW-1:0] BmodeLast   = CntW'(BMODE_HOLD - 1);
    localparam logic [DebW-1:0] DebLast     = DebW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        StWaitLock = 3'd0,
        StSettle   = 3'd1,
        StHoldRst  = 3'd2,
        StStagger  = 3'd3,
        StBmodeHld = 3'd4,
        StRun      = 3'd5
    } state_e;

    state_e state_q, state_d;

    logic [CntW-1:0] cnt_q, cnt_d;

    logic lock_meta_q, lock_s_q;
    logic btn_meta_q, btn_s_q;

    logic            deb_level_q, deb_level_d;
    logic [DebW-1:0] deb_cnt_q, deb_cnt_d;
    logic            deb_rise;

    logic restart;
    logic strap_load;

    logic       dsp0_rst_n_q, dsp0_rst_n_d;
    logic       dsp1_rst_n_q, dsp1_rst_n_d;
    logic [1:0] dsp0_bmode_q, dsp0_bmode_d;
    logic [1:0] dsp1_bmode_q, dsp1_bmode_d;
    logic       bypass_q, bypass_d;
    logic       boot_done_q, boot_done_d;

    // Two-flop synchronisers for the asynchronous lock and button inputs.
    always_ff @(posedge DSP_CLKIN) begin
        if (!xRESET) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
            btn_meta_q  <= 1'b0;
            btn_s_q     <= 1'b0;
        end else begin
            lock_meta_q <= LOCKED_IN;
            lock_s_q    <= lock_meta_q;
            btn_meta_q  <= BUTTON_IN;
            btn_s_q     <= btn_meta_q;
        end
    end

    always_comb begin
        deb_level_d = deb_level_q;
        deb_cnt_d   = '0;
        if (btn_s_q != deb_level_q) begin
            if (deb_cnt_q == DebLast) begin
                deb_level_d = btn_s_q;
            end else begin
                deb_cnt_d = deb_cnt_q + DebW'(1);
            end
        end
    end

    // Rise is taken from the next-state level so the restart lands on the qualifying edge.
    assign deb_rise = deb_level_d & ~deb_level_q;

    always_ff @(posedge DSP_CLKIN) begin
        if (!xRESET) begin
            deb_level_q <= 1'b0;
            deb_cnt_q   <= '0;
        end else begin
            deb_level_q <= deb_level_d;
            deb_cnt_q   <= deb_cnt_d;
        end
    end

    // State register, sequencing counter and registered Moore outputs.
    always_ff @(posedge DSP_CLKIN) begin
        if (!xRESET) begin
            state_q      <= StWaitLock;
            cnt_q        <= '0;
            dsp0_rst_n_q <= 1'b0;
            dsp1_rst_n_q <= 1'b0;
            dsp0_bmode_q <= BMODE_DEFAULT;
            dsp1_bmode_q <= BMODE_DEFAULT;
            bypass_q     <= 1'b0;
            boot_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dsp0_rst_n_q <= dsp0_rst_n_d;
            dsp1_rst_n_q <= dsp1_rst_n_d;
            dsp0_bmode_q <= dsp0_bmode_d;
            dsp1_bmode_q <= dsp1_bmode_d;
            bypass_q     <= bypass_d;
            boot_done_q  <= boot_done_d;
        end
    end

    // Next state: lock loss beats the button, the button beats the timed transitions.
    always_comb begin
        state_d = state_q;
        restart = 1'b0;
        if (state_q != StWaitLock && !lock_s_q) begin
            state_d = StWaitLock;
        end else if (deb_rise && (state_q inside {StHoldRst, StStagger, StBmodeHld, StRun})) begin
            state_d = StHoldRst;
            restart = 1'b1;
        end else begin
            unique case (state_q)
                StWaitLock: begin
                    if (lock_s_q) state_d = StSettle;
                end
                StSettle: begin
                    if (cnt_q == SettleLast) state_d = StHoldRst;
                end
                StHoldRst: begin
                    if (cnt_q == RstLast) begin
                        state_d = (STAGGER_CYCLES == 0) ? StBmodeHld : StStagger;
                    end
                end
                StStagger: begin
                    if (cnt_q == StaggerLast) state_d = StBmodeHld;
                end
                StBmodeHld: begin
                    if (cnt_q == BmodeLast) state_d = StRun;
                end
                StRun: begin
                    state_d = StRun;
                end
                default: begin
                    state_d = StWaitLock;
                end
            endcase
        end
    end

    always_comb begin
        cnt_d = '0;
        if (state_d == state_q && !restart &&
            (state_q inside {StSettle, StHoldRst, StStagger, StBmodeHld})) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    // Outputs decoded from the next state so they switch with the state register.
    always_comb begin
        strap_load   = (state_d == StHoldRst) && ((state_q != StHoldRst) || restart);
        dsp0_rst_n_d = state_d inside {StStagger, StBmodeHld, StRun};
        dsp1_rst_n_d = state_d inside {StBmodeHld, StRun};
        boot_done_d  = (state_d == StRun);
        dsp0_bmode_d = dsp0_bmode_q;
        dsp1_bmode_d = dsp1_bmode_q;
        bypass_d     = bypass_q;
        if (strap_load) begin
            dsp0_bmode_d = DSP0_BMODE_IN;
            dsp1_bmode_d = DSP1_BMODE_IN;
            bypass_d     = BYPASS_IN;
        end
    end

    assign DSP0_RESET_N   = dsp0_rst_n_q;
    assign DSP1_RESET_N   = dsp1_rst_n_q;
    assign DSP0_BMODE     = dsp0_bmode_q;
    assign DSP1_BMODE     = dsp1_bmode_q;
    assign DSP_PLL_BYPASS = bypass_q;
    assign BOOT_DONE      = boot_done_q;
    assign STATE_MON      = state_q;

endmodule
